// File: rtl/tri_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// tri_bus_arbiter_if
// Bundles the request/grant signals between the requesting units, the
// round-robin arbiter and the bufif1 enable pins of the shared-bus driver bank.
//
// Parameters
//   N      number of requesters / tri-state drivers
//   IDX_W  width of the OWNER index
//
// Signals
//   REQ       requester -> arbiter, one level request per requester
//   GNT       arbiter -> requester, registered one-hot grant
//   OE        arbiter -> driver bank, bufif1 enables (always equal to GNT)
//   OWNER     index of the current (or last) grantee
//   BUS_BUSY  high while any grant bit is set
//   TURN_ACT  high during all-off turnaround cycles
//
// Modports
//   master  the arbiter side (drives grant/enable/status)
//   slave   the requester / driver-bank side (drives REQ)
// ---------------------------------------------------------------------------
interface tri_bus_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = 2
);
    logic [N-1:0]     REQ;
    logic [N-1:0]     GNT;
    logic [N-1:0]     OE;
    logic [IDX_W-1:0] OWNER;
    logic             BUS_BUSY;
    logic             TURN_ACT;

    modport master (
        input  REQ,
        output GNT, OE, OWNER, BUS_BUSY, TURN_ACT
    );

    modport slave (
        output REQ,
        input  GNT, OE, OWNER, BUS_BUSY, TURN_ACT
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tri_bus_arbiter
// Round-robin arbiter for a shared tri-state net driven by N bufif1 drivers.
// Issues a registered one-hot grant and an identical per-driver output
// enable, and always inserts TURN_CYC all-off turnaround cycles between two
// owners so that no two drivers ever fight on the net.
//
// Optional feature (compile-time macro ARB_HOLD_LIMIT_EN):
//   when defined, an owner that has held the bus for MAX_HOLD grant cycles is
//   forced off if any other requester is waiting. When undefined, no hold
//   counter exists and MAX_HOLD has no effect.
//
// Parameters
//   N         number of requesters (2..8)
//   IDX_W     width of OWNER, N <= 2**IDX_W
//   TURN_CYC  all-off cycles between any two grants (>= 1)
//   MAX_HOLD  max tenure while others wait (>= 2), hold-limit build only
//
// Ports
//   CLK   rising-edge clock
//   RST   synchronous reset, active-high
//   bus   tri_bus_arbiter_if.master: REQ in; GNT, OE, OWNER, BUS_BUSY,
//         TURN_ACT out
// ---------------------------------------------------------------------------
module tri_bus_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = 2,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                CLK,
    input  logic                RST,
    tri_bus_arbiter_if.master   bus
);

    // Turn counter counts TURN_CYC-1 down to 0.
    localparam int TC_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    if (N < 2 || N > 8 || N > (1 << IDX_W) || TURN_CYC < 1 || MAX_HOLD < 2) begin : g_bad_param
        $error("tri_bus_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     gnt, gnt_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_nxt;
    logic [TC_W-1:0]  turn_cnt, turn_nxt;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
`endif

    // Round-robin pick: first set REQ bit scanning upward from rr_ptr,
    // wrapping from N-1 to 0.
    logic             found;
    logic [IDX_W-1:0] pick;

    always_comb begin
        logic [IDX_W-1:0] scan_idx;
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int i = 0; i < N; i++) begin
            scan_idx = IDX_W'((int'(rr_ptr) + i) % N);
            if (!found && bus.REQ[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    // Next-state / next-output logic.
    always_comb begin
        logic rel;
        state_nxt = state;
        gnt_nxt   = gnt;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        turn_nxt  = turn_cnt;
        rel       = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
        hold_nxt  = hold_cnt;
`endif

        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    owner_nxt     = pick;
                    state_nxt     = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                    hold_nxt      = '0;
`endif
                end
            end

            GRANT: begin
                rel = !bus.REQ[owner];
`ifdef ARB_HOLD_LIMIT_EN
                if (hold_cnt != HOLD_W'(MAX_HOLD - 1))
                    hold_nxt = hold_cnt + 1'b1;
                // Tenure used up and somebody else is waiting: force off.
                if (hold_cnt == HOLD_W'(MAX_HOLD - 1) && |(bus.REQ & ~gnt))
                    rel = 1'b1;
`endif
                if (rel) begin
                    gnt_nxt   = '0;
                    rr_nxt    = IDX_W'((int'(owner) + 1) % N);
                    turn_nxt  = TC_W'(TURN_CYC - 1);
                    state_nxt = TURN;
                end
            end

            TURN: begin
                if (turn_cnt == '0) begin
                    // Last all-off cycle: arbitrate on the REQ seen right now.
                    if (found) begin
                        gnt_nxt       = '0;
                        gnt_nxt[pick] = 1'b1;
                        owner_nxt     = pick;
                        state_nxt     = GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_nxt      = '0;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    turn_nxt = turn_cnt - 1'b1;
                end
            end

            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            turn_cnt <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            turn_cnt <= turn_nxt;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= hold_nxt;
`endif
        end
    end

    // OE is the grant register itself, so the two can never disagree.
    assign bus.GNT      = gnt;
    assign bus.OE       = gnt;
    assign bus.OWNER    = owner;
    assign bus.BUS_BUSY = |gnt;
    assign bus.TURN_ACT = (state == TURN);

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tri_bus_arbiter
// Directed bench for tri_bus_arbiter. Two instances: dut_a (TURN_CYC=1,
// MAX_HOLD=8) and dut_b (TURN_CYC=3). Each step pushes the expected post-edge
// outputs to a scoreboard queue, drives REQ, and after the edge pops the
// entry and compares it with the DUT. Hold-limit expectations follow
// ARB_HOLD_LIMIT_EN.
// ---------------------------------------------------------------------------
module tb_tri_bus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tri_bus_arbiter_if #(.N(4), .IDX_W(2)) bus_a ();
    tri_bus_arbiter_if #(.N(4), .IDX_W(2)) bus_b ();

    tri_bus_arbiter #(.N(4), .IDX_W(2), .TURN_CYC(1), .MAX_HOLD(8)) dut_a (
        .CLK (clk),
        .RST (rst),
        .bus (bus_a.master)
    );

    tri_bus_arbiter #(.N(4), .IDX_W(2), .TURN_CYC(3), .MAX_HOLD(8)) dut_b (
        .CLK (clk),
        .RST (rst),
        .bus (bus_b.master)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       turn;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic [3:0] prev_oe_a = '0;
    logic [3:0] prev_oe_b = '0;

    task automatic chk(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, what, got, exp);
        end
    endtask

    // One clock: REQ r is sampled at the coming edge; expected values are
    // the outputs visible in the cycle after that edge.
    task automatic step(input bit use_b, input logic [3:0] r,
                        input logic [3:0] eg, input logic [1:0] eo,
                        input logic eb, input logic et, input string tag);
        exp_t       e;
        logic [3:0] g, oe, prev;
        logic [1:0] ow;
        logic       bz, ta;
        e.gnt = eg; e.owner = eo; e.busy = eb; e.turn = et;
        sb.push_back(e);
        if (use_b) begin
            bus_b.REQ = r; bus_a.REQ = '0;
        end else begin
            bus_a.REQ = r; bus_b.REQ = '0;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (use_b) begin
            g = bus_b.GNT; oe = bus_b.OE; ow = bus_b.OWNER; bz = bus_b.BUS_BUSY; ta = bus_b.TURN_ACT; prev = prev_oe_b;
            prev_oe_b = oe;
        end else begin
            g = bus_a.GNT; oe = bus_a.OE; ow = bus_a.OWNER; bz = bus_a.BUS_BUSY; ta = bus_a.TURN_ACT; prev = prev_oe_a;
            prev_oe_a = oe;
        end
        chk(tag, "gnt",   32'(g),  32'(e.gnt));
        chk(tag, "oe",    32'(oe), 32'(e.gnt));
        chk(tag, "owner", 32'(ow), 32'(e.owner));
        chk(tag, "busy",  32'(bz), 32'(e.busy));
        chk(tag, "turn",  32'(ta), 32'(e.turn));
        chk(tag, "oe_onehot0", 32'($onehot0(oe)), 32'd1);
        chk(tag, "no_direct_switch", 32'(prev == '0 || oe == '0 || oe == prev), 32'd1);
    endtask

    initial begin
        logic [3:0] m;
        int         k;
        bus_a.REQ = '0;
        bus_b.REQ = '0;

        // 1. reset
        rst = 1'b1;
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rst0");
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rst1");
        step(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_b");
        rst = 1'b0;

        // 2. single grant, release, one turnaround cycle, idle
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "single_gnt");
        step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, "single_turn");
        step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "single_idle");

        // 1b. reset mid-grant (rr_ptr is 3 here, so requester 1 wins)
        step(0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "pre_rst_gnt");
        rst = 1'b1;
        step(0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_mid");
        rst = 1'b0;
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "post_rst_idle");

        // 3. all requesting, 3-cycle tenures: order 0,1,2,3,0
        for (int j = 0; j < 5; j++) begin
            k = j % 4;
            m = 4'b0001 << k;
            step(0, 4'b1111, m, 2'(k), 1'b1, 1'b0, "rr_gnt");
            step(0, 4'b1111, m, 2'(k), 1'b1, 1'b0, "rr_hold1");
            step(0, 4'b1111, m, 2'(k), 1'b1, 1'b0, "rr_hold2");
            step(0, 4'b1111 & ~m, 4'b0000, 2'(k), 1'b0, 1'b1, "rr_turn");
        end
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");

        // 5. owner drop and new REQ together; short REQ pulse never granted
        step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "sim_gnt0");
        step(0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1, "sim_turn");
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "sim_gnt2");
        step(0, 4'b0110, 4'b0100, 2'd2, 1'b1, 1'b0, "pulse_ign");
        step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "pulse_after");
        step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, "sim_rel");
        step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "sim_idle");

        // 6. hold limit: owner 0 holds, requester 1 waits
        step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_gnt");
        for (int j = 0; j < 7; j++)
            step(0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_keep");
`ifdef ARB_HOLD_LIMIT_EN
        step(0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1, "hold_forced");
        step(0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, "hold_next");
        step(0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1, "hold_rel");
        step(0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "hold_idle");
`else
        step(0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_nolimit");
        step(0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "hold_nolimit2");
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, "hold_rel");
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "hold_idle");
`endif
        // same owner alone: keeps the bus well past MAX_HOLD cycles
        step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "alone_gnt");
        for (int j = 0; j < 10; j++)
            step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "alone_keep");
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, "alone_rel");
        step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "alone_idle");

        // 4. TURN_CYC=3: owner 1 releases while requester 3 waits
        step(1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "t3_gnt1");
        step(1, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0, "t3_keep");
        step(1, 4'b1000, 4'b0000, 2'd1, 1'b0, 1'b1, "t3_turn1");
        step(1, 4'b1000, 4'b0000, 2'd1, 1'b0, 1'b1, "t3_turn2");
        step(1, 4'b1000, 4'b0000, 2'd1, 1'b0, 1'b1, "t3_turn3");
        step(1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "t3_gnt3");
        step(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1, "t3_rel_a");
        step(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1, "t3_rel_b");
        step(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b1, "t3_rel_c");
        step(1, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "t3_idle");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tri_bus_arbiter.md
Name: tri_bus_arbiter

Overview:
- Round-robin arbiter for a shared tri-state bus driven by N bufif1 drivers. One driver per requester, all on one tri net.
- Issues a one-hot grant and a matching per-driver output enable.
- Inserts mandatory all-off turnaround cycles between owners, so two drivers never fight on the net. The released bus floats to Z.
- Sits between requesting units and the bufif1 enable pins of the shared-bus driver bank.

Parameters:
- N, 4, number of requesters/drivers (2..8).
- IDX_W, 2, width of OWNER; N <= 2**IDX_W.
- TURN_CYC, 1, all-off turnaround cycles between any two grants (>= 1).
- MAX_HOLD, 8, maximum grant tenure in cycles when others are waiting (>= 2). Effective only with ARB_HOLD_LIMIT_EN.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- REQ  input  N  request per requester; level, held until done with the bus.
- GNT  output  N  registered one-hot grant.
- OE  output  N  registered driver enables to bufif1 control pins; always equal to GNT.
- OWNER  output  IDX_W  index of current grantee; holds the last owner when no grant is active.
- BUS_BUSY  output  1  high while any GNT bit is set.
- TURN_ACT  output  1  high during turnaround cycles.

Behaviour:
- Reset (RST high at an edge): state IDLE; GNT=0, OE=0, OWNER=0, BUS_BUSY=0, TURN_ACT=0; RR pointer=0; hold and turn counters=0.
- Reset mid-grant: OE drops at that edge, the bus floats, and the in-progress tenure is discarded.
- Arbitration: pick the first set REQ bit scanning upward from the RR pointer, wrapping from N-1 to 0.
- IDLE:
  - If REQ!=0 at edge t: GNT/OE[k] set at that edge, visible in cycle t+1 (1-cycle latency); OWNER=k; go to GRANT.
  - Otherwise remain in IDLE.
- GRANT:
  - GNT[k]=OE[k]=1, BUS_BUSY=1.
  - The hold counter increments each cycle and saturates at MAX_HOLD-1.
  - Release when REQ[k]=0 is sampled.
  - On release: GNT/OE cleared at the same edge; RR pointer = (k+1) mod N; turn counter loaded; go to TURN.
  - An owner that keeps REQ high keeps the bus indefinitely unless the hold limit applies (see Optional Feature).
- TURN:
  - GNT=OE=0, TURN_ACT=1, BUS_BUSY=0, lasting exactly TURN_CYC cycles.
  - On the edge ending the last turn cycle, arbitrate on current REQ:
    - winner found: go to GRANT, with GNT set at that edge;
    - no requester: go to IDLE.
  - Gap between two grants is therefore exactly TURN_CYC cycles.
- Invariants:
  - OE is at most one-hot in every cycle.
  - OE never switches directly between two different owners.
  - GNT equals OE in every cycle.
- Simultaneous events:
  - Owner drop plus new REQ in the same cycle: still TURN first.
  - A REQ that rises and falls while another requester owns the bus is never granted; requests are sampled only at arbitration.
  - The former owner re-requesting during TURN has the lowest priority at the next arbitration.
- REQ of non-owners during GRANT is ignored except by the hold-limit check.

Optional Feature:
- Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - When the hold counter reaches MAX_HOLD-1 and any other REQ bit is set, force release at the next edge even if REQ[k] is still high.
  - The forced owner is treated as a normal release: RR pointer = k+1, then TURN.
  - With no other requester, the counter saturates and the owner keeps the bus.
- Undefined:
  - The hold counter is not built; release happens only on REQ[k]=0.
  - MAX_HOLD is ignored.

Test Plan:
1. RST high 2 cycles, then REQ=4'b0000 -> GNT=OE=0, OWNER=0, BUS_BUSY=0, TURN_ACT=0; reset asserted mid-grant clears OE at the next edge.
2. From IDLE, REQ=4'b0100 at edge t -> GNT=4'b0100 and OWNER=2 in cycle t+1. Drop REQ -> one cycle with OE=0 and TURN_ACT=1 -> IDLE.
3. REQ=4'b1111 held, each owner releases after 3 grant cycles -> grant order 0,1,2,3,0. Each tenure is separated by exactly 1 all-zero OE cycle; OE is never more than one-hot.
4. TURN_CYC=3, owner 1 releases while REQ[3]=1 -> 3 cycles of OE=0, then GNT=4'b1000.
5. Owner 0 drops REQ in the same cycle REQ[2] rises -> TURN first, then GNT=4'b0100; a REQ[1] pulse of 1 cycle during owner 2's tenure is never granted.
6. ARB_HOLD_LIMIT_EN defined, MAX_HOLD=8: owner 0 holds REQ, REQ[1]=1 -> forced release after 8 grant cycles, TURN, GNT=4'b0010. Same stimulus without REQ[1] -> owner 0 keeps the bus past 8 cycles. Macro undefined -> no forced release.
